// File: rtl/scm_stream_pkg.sv
// Shared types and constants for the SCM stream load/dump controller.
package scm_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/scm_stream_if.sv
// Control, stream and register-file port bundle of scm_stream_ctrl.
// Defining SCM_STREAM_BE_EN adds the per-byte load enable in_be_i.
interface scm_stream_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  start_i;
  logic                  mode_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH:0]   count_i;
  logic                  busy_o;
  logic                  done_o;

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
`ifdef SCM_STREAM_BE_EN
  logic [BE_WIDTH-1:0]   in_be_i;
`endif

  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;

  logic                  rf_read_enable_o;
  logic [ADDR_WIDTH-1:0] rf_read_addr_o;
  logic [DATA_WIDTH-1:0] rf_read_data_i;
  logic                  rf_write_enable_o;
  logic [ADDR_WIDTH-1:0] rf_write_addr_o;
  logic [DATA_WIDTH-1:0] rf_write_data_o;
  logic [BE_WIDTH-1:0]   rf_write_be_o;

  // master is the controller; slave is the streamer / register-file side
  modport master (
    input  start_i, mode_i, base_addr_i, count_i,
    input  in_valid_i, in_data_i,
`ifdef SCM_STREAM_BE_EN
    input  in_be_i,
`endif
    input  out_ready_i, rf_read_data_i,
    output busy_o, done_o, in_ready_o, out_valid_o, out_data_o,
    output rf_read_enable_o, rf_read_addr_o,
    output rf_write_enable_o, rf_write_addr_o, rf_write_data_o, rf_write_be_o
  );

  modport slave (
    output start_i, mode_i, base_addr_i, count_i,
    output in_valid_i, in_data_i,
`ifdef SCM_STREAM_BE_EN
    output in_be_i,
`endif
    output out_ready_i, rf_read_data_i,
    input  busy_o, done_o, in_ready_o, out_valid_o, out_data_o,
    input  rf_read_enable_o, rf_read_addr_o,
    input  rf_write_enable_o, rf_write_addr_o, rf_write_data_o, rf_write_be_o
  );

endinterface

// File: rtl/scm_stream_fifo2.sv
// Two-entry valid/ready buffer: head register feeds the consumer, tail
// register absorbs the second word while the consumer stalls.
module scm_stream_fifo2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       level_q;
  logic             push_ok;
  logic             pop_ok;

  assign valid   = (level_q != 2'd0);
  assign head    = head_q;
  assign level   = level_q;
  assign pop_ok  = pop && valid;
  assign push_ok = push && (level_q != 2'd2);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset only because the head drives
      // out_data directly and must read zero after reset.
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= 2'd0;
    end else if (flush) begin
      level_q <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (level_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          level_q <= level_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          level_q <= level_q - 2'd1;
        end
        2'b11: begin
          if (level_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/scm_stream_ctrl.sv
// Load/dump controller driving the 1R/1W register file from valid/ready streams.
// Optional feature macro: SCM_STREAM_BE_EN (per-byte load enables via in_be_i).
module scm_stream_ctrl
  import scm_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input logic         clk,
  input logic         rst,
  scm_stream_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  state_e                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   out_left;
  logic                  inflight;

  logic                  start_ok;
  logic                  write_fire;
  logic                  read_fire;
  logic                  pop_fire;
  logic                  fifo_valid;
  logic [1:0]            fifo_level;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [2:0]            occupancy;

  assign start_ok   = (state == IDLE) && bus.start_i;
  assign write_fire = (state == LOAD) && bus.in_valid_i;
  assign pop_fire   = fifo_valid && bus.out_ready_i;
  assign occupancy  = {1'b0, fifo_level} + {2'b00, inflight};

  // A word leaving the buffer this cycle frees its slot for a read issued in
  // the same cycle; this keeps one word per cycle with the consumer ready.
  assign read_fire  = (state == DUMP) && (remaining != '0) &&
                      (occupancy < (3'd2 + {2'b00, pop_fire}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      out_left  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= read_fire;
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            addr      <= bus.base_addr_i;
            remaining <= bus.count_i;
            out_left  <= bus.count_i;
            if (bus.count_i == '0)            state <= DONE;
            else if (bus.mode_i == MODE_LOAD) state <= LOAD;
            else                              state <= DUMP;
          end
        end
        LOAD: begin
          if (write_fire) begin
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) state <= DONE;
          end
        end
        DUMP: begin
          if (read_fire) begin
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
          end
          if (pop_fire) begin
            out_left <= out_left - CNT_ONE;
            if (out_left == CNT_ONE) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  scm_stream_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start_ok),
    .push      (inflight),
    .push_data (bus.rf_read_data_i),
    .pop       (pop_fire),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .level     (fifo_level)
  );

  assign bus.busy_o            = (state != IDLE);
  assign bus.done_o            = (state == DONE);
  assign bus.in_ready_o        = (state == LOAD);
  assign bus.out_valid_o       = fifo_valid;
  assign bus.out_data_o        = fifo_head;
  assign bus.rf_write_enable_o = write_fire;
  assign bus.rf_write_addr_o   = write_fire ? addr : '0;
  assign bus.rf_write_data_o   = write_fire ? bus.in_data_i : '0;
  assign bus.rf_read_enable_o  = read_fire;
  assign bus.rf_read_addr_o    = read_fire ? addr : '0;

`ifdef SCM_STREAM_BE_EN
  assign bus.rf_write_be_o = write_fire ? bus.in_be_i : '1;
`else
  assign bus.rf_write_be_o = '1;
`endif

endmodule

// File: doc/scm_stream_ctrl.md
# scm_stream_ctrl

Streaming load/dump controller for the byte-enabled 1-read/1-write standard-cell-memory register file. It is the initiator that drives the register file's write and read ports. In load mode it writes a block of words received on a valid/ready input stream. In dump mode it issues reads, absorbs the register file's one-cycle registered read latency, and emits the words on a valid/ready output stream under backpressure. It sits between DMA/streamer logic and the register file instance.

## Interface
- ADDR_WIDTH, 5, register file address width; depth is 2**ADDR_WIDTH
- DATA_WIDTH, 64, word width; multiple of 8
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  begin transfer; sampled only in IDLE
- mode_i  in  1  0 = dump, 1 = load; sampled with start_i
- base_addr_i  in  ADDR_WIDTH  first word address
- count_i  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- in_valid_i / in_ready_o  in/out  1  load stream handshake
- in_data_i  in  DATA_WIDTH  load word
- out_valid_o / out_ready_i  out/in  1  dump stream handshake
- out_data_o  out  DATA_WIDTH  dump word
- rf_read_enable_o  out  1  read strobe
- rf_read_addr_o  out  ADDR_WIDTH  read address
- rf_read_data_i  in  DATA_WIDTH  read data; valid the cycle after the address is presented
- rf_write_enable_o  out  1  write strobe
- rf_write_addr_o  out  ADDR_WIDTH  write address
- rf_write_data_o  out  DATA_WIDTH  write data
- rf_write_be_o  out  DATA_WIDTH/8  byte enables

## Operation
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- States: IDLE, LOAD, DUMP, DONE.
- IDLE -> LOAD or DUMP on start_i. Address counter loads base_addr_i; remaining-count register loads count_i.
- start_i with count_i = 0: transition straight to DONE. No memory access is made.
- start_i is ignored outside IDLE.
- LOAD:
  - in_ready_o = 1.
  - On each in_valid_i & in_ready_o: rf_write_enable_o = 1, rf_write_addr_o = address counter, rf_write_data_o = in_data_i. These outputs are combinational from the handshake.
  - Address increments; count decrements.
  - After the last handshake, go to DONE.
- DUMP:
  - A 2-entry output buffer holds read data.
  - A read is issued (rf_read_enable_o = 1, rf_read_addr_o = address counter) only if words remaining > 0 and (buffered entries + reads in flight) < 2.
  - rf_read_data_i is captured into the buffer on the cycle following each issued read.
  - out_valid_o = buffer non-empty; out_data_o = buffer head.
  - After the last word is accepted (out_valid_o & out_ready_i), go to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- busy_o = 1 in LOAD, DUMP and DONE.
- Address arithmetic is modulo 2**ADDR_WIDTH: base 2**ADDR_WIDTH-1 wraps to 0.
- out_data_o stays stable while out_valid_o = 1 and out_ready_i = 0.
- out_valid_o never drops without a handshake.
- Outside their active states: in_ready_o = 0, rf_write_enable_o = 0, rf_read_enable_o = 0.
- Reset mid-transfer: state returns to IDLE, buffer is flushed, no further accesses. Words already written stay in memory.

## Timing
- Reset values:
  - busy_o, done_o, in_ready_o, out_valid_o, rf_read_enable_o, rf_write_enable_o = 0
  - out_data_o, rf_read_addr_o, rf_write_addr_o, rf_write_data_o = 0
  - rf_write_be_o = all ones
- Load latency: start_i sampled in cycle 0; in_ready_o = 1 from cycle 1. A handshake in cycle k writes memory at the edge ending cycle k. done_o pulses in cycle k+1 after the last handshake k.
- Dump latency: start_i in cycle 0; first read in cycle 1; data captured at the end of cycle 2; out_valid_o = 1 from cycle 3.
- Dump throughput: with out_ready_i held high, one word per cycle. done_o pulses the cycle after the final output handshake.
- Backpressure: at most 2 words are held or in flight. Reads stall within one cycle of a full buffer and resume the cycle after a pop.

## Configuration
- SCM_STREAM_BE_EN defined:
  - Adds input port in_be_i [DATA_WIDTH/8-1:0], qualified by in_valid_i.
  - rf_write_be_o = in_be_i during load handshakes, otherwise all ones.
- SCM_STREAM_BE_EN undefined: no in_be_i port; rf_write_be_o is tied to all ones.

## Structure
- Package scm_stream_pkg:
  - state enum typedef (IDLE, LOAD, DUMP, DONE)
  - mode localparams MODE_DUMP = 1'b0, MODE_LOAD = 1'b1
- Sub-module scm_stream_fifo2: 2-entry valid/ready buffer with push, pop and flush. It holds the dump data path.

## Test plan
- Load then dump: load base 3, count 4, words 0xA0..0xA3 with in_valid_i held high. Required: writes at addresses 3..6 in cycles 1..4; done_o in cycle 5. Dump of the same range returns 0xA0..0xA3 on consecutive cycles from cycle 3.
- Wrap-around: ADDR_WIDTH = 5, base 30, count 4. Required: addresses 30, 31, 0, 1 in order for both load and dump.
- Backpressure: dump count 8 with out_ready_i toggling 1-0-0-1. Required: no word lost or duplicated, out_data_o stable while stalled, at most 2 reads ahead of the consumer.
- Edge cases:
  - count_i = 0: done_o pulses in cycle 1 with no strobes.
  - start_i asserted while busy_o = 1: ignored.
  - count_i = 32: full-memory transfer.
- Reset mid-dump: assert rst after 3 words are emitted. Required: all outputs return to reset values immediately; the next start_i behaves normally.
- With SCM_STREAM_BE_EN: load 0xFFFF_FFFF_FFFF_FFFF over 0 using in_be_i = 0x0F. Required: memory word = 0x0000_0000_FFFF_FFFF.
